// File: rtl/tlb_pkg.sv
// tlb_pkg: shared definitions for the TLB maintenance controller.
//   - request op encodings
//   - packed TLB entry width and field bit positions
//   - controller FSM state enum
//   - invtlb op legality helper
package tlb_pkg;

  localparam int ENTRY_W = 89;

  localparam logic [2:0] TLB_OP_SRCH = 3'd0;
  localparam logic [2:0] TLB_OP_RD   = 3'd1;
  localparam logic [2:0] TLB_OP_WR   = 3'd2;
  localparam logic [2:0] TLB_OP_FILL = 3'd3;
  localparam logic [2:0] TLB_OP_INV  = 3'd4;

  // Entry field layout (bit positions inside the packed entry)
  localparam int E_BIT    = 0;
  localparam int ASID_LSB = 1;
  localparam int ASID_MSB = 10;
  localparam int G_BIT    = 11;
  localparam int PS_LSB   = 12;
  localparam int PS_MSB   = 17;
  localparam int VPPN_LSB = 18;
  localparam int VPPN_MSB = 36;
  localparam int LO0_LSB  = 37;  // V0/D0/MAT0/PLV0/PPN0
  localparam int LO0_MSB  = 62;
  localparam int LO1_LSB  = 63;  // V1/D1/MAT1/PLV1/PPN1
  localparam int LO1_MSB  = 88;

  localparam logic [4:0] INV_OP_MAX = 5'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRCH_WAIT,
    S_RD_WAIT,
    S_CAPT,
    S_RESP
  } tlb_state_e;

  function automatic logic inv_op_legal(input logic [4:0] op);
    return op <= INV_OP_MAX;
  endfunction

endpackage

// File: rtl/tlb_ctrl_if.sv
// tlb_ctrl_if: request/response channel between the EXE/MEM stage and the
// TLB controller.
//   master : requester side (drives req_*, receives req_ready and resp_*)
//   slave  : controller side
//   req_valid/req_ready  : request handshake, accepted when both high
//   req_op/index/entry   : operation, RD/WR index, entry (WR/FILL data, SRCH key)
//   req_inv_op/asid/vpn  : invtlb operands
//   resp_valid           : one-cycle completion pulse, no backpressure
//   resp_hit/err/index/entry : response payload, zero while resp_valid=0
interface tlb_ctrl_if
  import tlb_pkg::*;
#(
  parameter int TLBNum = 32,
  parameter int EntryW = ENTRY_W
);
  localparam int IDXW = $clog2(TLBNum);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [IDXW-1:0]   req_index;
  logic [EntryW-1:0] req_entry;
  logic [4:0]        req_inv_op;
  logic [9:0]        req_inv_asid;
  logic [18:0]       req_inv_vpn;

  logic              resp_valid;
  logic              resp_hit;
  logic              resp_err;
  logic [IDXW-1:0]   resp_index;
  logic [EntryW-1:0] resp_entry;

  modport master (
    output req_valid, req_op, req_index, req_entry,
           req_inv_op, req_inv_asid, req_inv_vpn,
    input  req_ready, resp_valid, resp_hit, resp_err, resp_index, resp_entry
  );

  modport slave (
    input  req_valid, req_op, req_index, req_entry,
           req_inv_op, req_inv_asid, req_inv_vpn,
    output req_ready, resp_valid, resp_hit, resp_err, resp_index, resp_entry
  );

endinterface

// File: rtl/tlb_fill_ctr.sv
// tlb_fill_ctr: round-robin fill index, counts 0..TLBNum-1 and wraps.
//   clk, rst (async, active-low)
//   inc : advance by one at the end of the current cycle
//   cnt : current fill index
module tlb_fill_ctr #(
  parameter int TLBNum = 32,
  localparam int IDXW = $clog2(TLBNum)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  output logic [IDXW-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (cnt == IDXW'(TLBNum - 1)) ? '0 : cnt + IDXW'(1);
    end
  end

endmodule

// File: rtl/tlb_ctrl.sv
// tlb_ctrl: initiator side of the TLB entry storage. Takes one maintenance
// request at a time (SRCH/RD/WR/FILL/INV), drives the storage ports, waits
// for registered storage results and returns one response pulse.
//   clk, rst (async, active-low)
//   req_if     : request/response channel (slave modport)
//   srch_*     : storage search port (found/index registered in storage)
//   rd_*       : storage read port (entry registered in storage)
//   we/w_*     : storage write port
//   inv_*      : storage invalidate port
// All outputs are registered.
module tlb_ctrl
  import tlb_pkg::*;
#(
  parameter int TLBNum = 32,
  parameter int EntryW = ENTRY_W,
  localparam int IDXW = $clog2(TLBNum)
) (
  input  logic              clk,
  input  logic              rst,
  tlb_ctrl_if.slave         req_if,
  output logic [18:0]       srch_vppn,
  output logic [9:0]        srch_asid,
  input  logic              srch_found,
  input  logic [IDXW-1:0]   srch_index,
  output logic [IDXW-1:0]   rd_index,
  input  logic [EntryW-1:0] rd_entry,
  output logic              we,
  output logic [IDXW-1:0]   w_index,
  output logic [EntryW-1:0] w_entry,
  output logic              inv_en,
  output logic [4:0]        inv_op,
  output logic [9:0]        inv_asid,
  output logic [18:0]       inv_vpn
);

  tlb_state_e      state;
  logic [2:0]      op_q;
  logic [IDXW-1:0] fill_cnt;
  logic            fill_inc;

  // The fill write is visible during RESP; advancing at its end means the
  // next FILL (accepted no earlier than IDLE) sees the new index.
  assign fill_inc = (state == S_RESP) && (op_q == TLB_OP_FILL);

  tlb_fill_ctr #(.TLBNum(TLBNum)) u_fill_ctr (
    .clk (clk),
    .rst (rst),
    .inc (fill_inc),
    .cnt (fill_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= S_IDLE;
      op_q              <= '0;
      req_if.req_ready  <= 1'b1;
      req_if.resp_valid <= 1'b0;
      req_if.resp_hit   <= 1'b0;
      req_if.resp_err   <= 1'b0;
      req_if.resp_index <= '0;
      req_if.resp_entry <= '0;
      srch_vppn         <= '0;
      srch_asid         <= '0;
      rd_index          <= '0;
      we                <= 1'b0;
      w_index           <= '0;
      w_entry           <= '0;
      inv_en            <= 1'b0;
      inv_op            <= '0;
      inv_asid          <= '0;
      inv_vpn           <= '0;
    end else begin
      case (state)
        // Accept stage: latch the request straight into the storage ports
        S_IDLE: begin
          if (req_if.req_valid) begin
            op_q             <= req_if.req_op;
            req_if.req_ready <= 1'b0;
            case (req_if.req_op)
              TLB_OP_SRCH: begin
                srch_vppn <= req_if.req_entry[VPPN_MSB:VPPN_LSB];
                srch_asid <= req_if.req_entry[ASID_MSB:ASID_LSB];
                state     <= S_SRCH_WAIT;
              end
              TLB_OP_RD: begin
                rd_index <= req_if.req_index;
                state    <= S_RD_WAIT;
              end
              TLB_OP_WR: begin
                we                <= 1'b1;
                w_index           <= req_if.req_index;
                w_entry           <= req_if.req_entry;
                req_if.resp_valid <= 1'b1;
                req_if.resp_index <= req_if.req_index;
                state             <= S_RESP;
              end
              TLB_OP_FILL: begin
                we                <= 1'b1;
                w_index           <= fill_cnt;
                w_entry           <= req_if.req_entry;
                req_if.resp_valid <= 1'b1;
                req_if.resp_index <= fill_cnt;
                state             <= S_RESP;
              end
              TLB_OP_INV: begin
                if (inv_op_legal(req_if.req_inv_op)) begin
                  inv_en   <= 1'b1;
                  inv_op   <= req_if.req_inv_op;
                  inv_asid <= req_if.req_inv_asid;
                  inv_vpn  <= req_if.req_inv_vpn;
                end else begin
                  req_if.resp_err <= 1'b1;
                end
                req_if.resp_valid <= 1'b1;
                state             <= S_RESP;
              end
              default: begin
                req_if.resp_valid <= 1'b1;
                req_if.resp_err   <= 1'b1;
                state             <= S_RESP;
              end
            endcase
          end
        end
        // Storage registers its result during this cycle
        S_SRCH_WAIT, S_RD_WAIT: begin
          state <= S_CAPT;
        end
        // Capture stage: storage result is valid now
        S_CAPT: begin
          req_if.resp_valid <= 1'b1;
          if (op_q == TLB_OP_SRCH) begin
            req_if.resp_hit   <= srch_found;
            req_if.resp_index <= srch_found ? srch_index : '0;
          end else begin
            req_if.resp_index <= rd_index;
            // An invalid entry is returned as all zeros
            req_if.resp_entry <= rd_entry[E_BIT] ? rd_entry : '0;
          end
          srch_vppn <= '0;
          srch_asid <= '0;
          rd_index  <= '0;
          state     <= S_RESP;
        end
        // Response stage: single-cycle pulse, then back to idle
        S_RESP: begin
          req_if.resp_valid <= 1'b0;
          req_if.resp_hit   <= 1'b0;
          req_if.resp_err   <= 1'b0;
          req_if.resp_index <= '0;
          req_if.resp_entry <= '0;
          we                <= 1'b0;
          w_index           <= '0;
          w_entry           <= '0;
          inv_en            <= 1'b0;
          inv_op            <= '0;
          inv_asid          <= '0;
          inv_vpn           <= '0;
          req_if.req_ready  <= 1'b1;
          state             <= S_IDLE;
        end
        default: begin
          req_if.req_ready <= 1'b1;
          state            <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
module tb_tlb_ctrl;
  import tlb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: 32 entries
  tlb_ctrl_if #(.TLBNum(32)) ifa ();
  logic [18:0] a_srch_vppn;
  logic [9:0]  a_srch_asid;
  logic        a_srch_found;
  logic [4:0]  a_srch_index;
  logic [4:0]  a_rd_index;
  logic [88:0] a_rd_entry;
  logic        a_we;
  logic [4:0]  a_w_index;
  logic [88:0] a_w_entry;
  logic        a_inv_en;
  logic [4:0]  a_inv_op;
  logic [9:0]  a_inv_asid;
  logic [18:0] a_inv_vpn;

  tlb_ctrl #(.TLBNum(32)) dut_a (
    .clk(clk), .rst(rst), .req_if(ifa),
    .srch_vppn(a_srch_vppn), .srch_asid(a_srch_asid),
    .srch_found(a_srch_found), .srch_index(a_srch_index),
    .rd_index(a_rd_index), .rd_entry(a_rd_entry),
    .we(a_we), .w_index(a_w_index), .w_entry(a_w_entry),
    .inv_en(a_inv_en), .inv_op(a_inv_op), .inv_asid(a_inv_asid), .inv_vpn(a_inv_vpn)
  );

  // DUT B: 4 entries, used for fill wrap
  tlb_ctrl_if #(.TLBNum(4)) ifb ();
  logic [18:0] b_srch_vppn;
  logic [9:0]  b_srch_asid;
  logic        b_srch_found = 1'b0;
  logic [1:0]  b_srch_index = 2'd0;
  logic [1:0]  b_rd_index;
  logic [88:0] b_rd_entry = '0;
  logic        b_we;
  logic [1:0]  b_w_index;
  logic [88:0] b_w_entry;
  logic        b_inv_en;
  logic [4:0]  b_inv_op;
  logic [9:0]  b_inv_asid;
  logic [18:0] b_inv_vpn;

  tlb_ctrl #(.TLBNum(4)) dut_b (
    .clk(clk), .rst(rst), .req_if(ifb),
    .srch_vppn(b_srch_vppn), .srch_asid(b_srch_asid),
    .srch_found(b_srch_found), .srch_index(b_srch_index),
    .rd_index(b_rd_index), .rd_entry(b_rd_entry),
    .we(b_we), .w_index(b_w_index), .w_entry(b_w_entry),
    .inv_en(b_inv_en), .inv_op(b_inv_op), .inv_asid(b_inv_asid), .inv_vpn(b_inv_vpn)
  );

  // Storage model for DUT A: registered search and read results
  localparam logic [88:0] ENT5 = 89'h1_2345_6789_abcd_ef01_2345;  // E=1
  localparam logic [88:0] ENT7 = 89'h0_fedc_ba98_7654_3210_fffe;  // E=0
  always_ff @(posedge clk) begin
    a_srch_found <= (a_srch_vppn == 19'h12345) && (a_srch_asid == 10'd3);
    a_srch_index <= ((a_srch_vppn == 19'h12345) && (a_srch_asid == 10'd3)) ? 5'd5 : 5'd9;
    case (a_rd_index)
      5'd5:    a_rd_entry <= ENT5;
      5'd7:    a_rd_entry <= ENT7;
      default: a_rd_entry <= '0;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request on A in the current cycle; returns in cycle N+1
  task automatic req_a(input logic [2:0] op, input logic [4:0] idx, input logic [88:0] ent,
                       input logic [4:0] iop, input logic [9:0] ias, input logic [18:0] ivp);
    ifa.req_valid = 1'b1;
    ifa.req_op = op; ifa.req_index = idx; ifa.req_entry = ent;
    ifa.req_inv_op = iop; ifa.req_inv_asid = ias; ifa.req_inv_vpn = ivp;
    tick();
    ifa.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (ifa.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0h exp 1", ifa.req_ready); end
    checks++; if ({ifa.resp_valid, ifa.resp_hit, ifa.resp_err, ifa.resp_index, ifa.resp_entry} !== '0) begin
      errors++; $display("FAIL rst_resp got nonzero response outputs"); end
    checks++; if ({a_srch_vppn, a_srch_asid, a_rd_index, a_we, a_w_index, a_w_entry,
                   a_inv_en, a_inv_op, a_inv_asid, a_inv_vpn} !== '0) begin
      errors++; $display("FAIL rst_storage got nonzero storage outputs"); end
  endtask

  task automatic test_write();
    req_a(TLB_OP_WR, 5'd5, 89'h48D140001, 5'd0, 10'd0, 19'd0);
    checks++; if (a_we !== 1'b1) begin errors++; $display("FAIL wr_we got %0h exp 1", a_we); end
    checks++; if (a_w_index !== 5'd5) begin errors++; $display("FAIL wr_index got %0d exp 5", a_w_index); end
    checks++; if (a_w_entry !== 89'h48D140001) begin errors++; $display("FAIL wr_entry got %0h exp 48d140001", a_w_entry); end
    checks++; if (ifa.resp_valid !== 1'b1 || ifa.resp_index !== 5'd5) begin
      errors++; $display("FAIL wr_resp got v=%0h i=%0d exp v=1 i=5", ifa.resp_valid, ifa.resp_index); end
    checks++; if (ifa.req_ready !== 1'b0 || a_inv_en !== 1'b0) begin
      errors++; $display("FAIL wr_ready_inv got r=%0h inv=%0h exp 0 0", ifa.req_ready, a_inv_en); end
    tick();
    checks++; if (a_we !== 1'b0 || ifa.resp_valid !== 1'b0 || ifa.req_ready !== 1'b1) begin
      errors++; $display("FAIL wr_after got we=%0h v=%0h r=%0h exp 0 0 1", a_we, ifa.resp_valid, ifa.req_ready); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 3; i++) begin
      req_a(TLB_OP_FILL, 5'd17, 89'h1, 5'd0, 10'd0, 19'd0);
      checks++; if (a_we !== 1'b1 || a_w_index !== 5'(i) || ifa.resp_index !== 5'(i)) begin
        errors++; $display("FAIL fill_%0d got we=%0h w=%0d r=%0d exp 1 %0d %0d", i, a_we, a_w_index, ifa.resp_index, i, i); end
      tick();
    end
  endtask

  task automatic test_fill_wrap();
    logic [1:0] exp_seq [6];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 6; i++) begin
      ifb.req_valid = 1'b1; ifb.req_op = TLB_OP_FILL; ifb.req_index = 2'd0; ifb.req_entry = 89'h1;
      ifb.req_inv_op = '0; ifb.req_inv_asid = '0; ifb.req_inv_vpn = '0;
      tick();
      ifb.req_valid = 1'b0;
      checks++; if (b_we !== 1'b1 || b_w_index !== exp_seq[i]) begin
        errors++; $display("FAIL fillwrap_%0d got we=%0h w=%0d exp 1 %0d", i, b_we, b_w_index, exp_seq[i]); end
      tick();
    end
  endtask

  task automatic test_search();
    // hit
    req_a(TLB_OP_SRCH, 5'd0, 89'h48D140006, 5'd0, 10'd0, 19'd0);  // vppn 12345, asid 3
    checks++; if (a_srch_vppn !== 19'h12345 || a_srch_asid !== 10'd3) begin
      errors++; $display("FAIL srch_ports got %0h/%0d exp 12345/3", a_srch_vppn, a_srch_asid); end
    checks++; if (ifa.resp_valid !== 1'b0 || ifa.req_ready !== 1'b0) begin
      errors++; $display("FAIL srch_n1 got v=%0h r=%0h exp 0 0", ifa.resp_valid, ifa.req_ready); end
    tick();
    checks++; if (ifa.resp_valid !== 1'b0 || a_srch_vppn !== 19'h12345) begin
      errors++; $display("FAIL srch_n2 got v=%0h vppn=%0h exp 0 12345", ifa.resp_valid, a_srch_vppn); end
    tick();
    checks++; if (ifa.resp_valid !== 1'b1 || ifa.resp_hit !== 1'b1 || ifa.resp_index !== 5'd5) begin
      errors++; $display("FAIL srch_hit got v=%0h h=%0h i=%0d exp 1 1 5", ifa.resp_valid, ifa.resp_hit, ifa.resp_index); end
    tick();
    checks++; if (ifa.resp_valid !== 1'b0 || ifa.resp_hit !== 1'b0) begin
      errors++; $display("FAIL srch_after got v=%0h h=%0h exp 0 0", ifa.resp_valid, ifa.resp_hit); end
    // miss: vppn 11111, asid 3
    req_a(TLB_OP_SRCH, 5'd0, 89'h444440006, 5'd0, 10'd0, 19'd0);
    tick(); tick();
    checks++; if (ifa.resp_valid !== 1'b1 || ifa.resp_hit !== 1'b0 || ifa.resp_index !== 5'd0) begin
      errors++; $display("FAIL srch_miss got v=%0h h=%0h i=%0d exp 1 0 0", ifa.resp_valid, ifa.resp_hit, ifa.resp_index); end
    tick();
  endtask

  task automatic test_read();
    req_a(TLB_OP_RD, 5'd5, 89'h0, 5'd0, 10'd0, 19'd0);
    checks++; if (a_rd_index !== 5'd5) begin errors++; $display("FAIL rd_index got %0d exp 5", a_rd_index); end
    tick();
    checks++; if (ifa.resp_valid !== 1'b0) begin errors++; $display("FAIL rd_n2 got v=%0h exp 0", ifa.resp_valid); end
    tick();
    checks++; if (ifa.resp_valid !== 1'b1 || ifa.resp_entry !== ENT5 || ifa.resp_index !== 5'd5) begin
      errors++; $display("FAIL rd_valid got v=%0h e=%0h i=%0d exp 1 %0h 5", ifa.resp_valid, ifa.resp_entry, ifa.resp_index, ENT5); end
    tick();
    req_a(TLB_OP_RD, 5'd7, 89'h0, 5'd0, 10'd0, 19'd0);
    tick(); tick();
    checks++; if (ifa.resp_valid !== 1'b1 || ifa.resp_entry !== 89'h0) begin
      errors++; $display("FAIL rd_invalid got v=%0h e=%0h exp 1 0", ifa.resp_valid, ifa.resp_entry); end
    tick();
  endtask

  task automatic test_inv();
    req_a(TLB_OP_INV, 5'd0, 89'h0, 5'd5, 10'd3, 19'h12345);
    checks++; if (a_inv_en !== 1'b1 || a_inv_op !== 5'd5 || a_inv_asid !== 10'd3 || a_inv_vpn !== 19'h12345) begin
      errors++; $display("FAIL inv_fields got en=%0h op=%0d a=%0d v=%0h exp 1 5 3 12345", a_inv_en, a_inv_op, a_inv_asid, a_inv_vpn); end
    checks++; if (ifa.resp_valid !== 1'b1 || ifa.resp_err !== 1'b0 || a_we !== 1'b0) begin
      errors++; $display("FAIL inv_resp got v=%0h err=%0h we=%0h exp 1 0 0", ifa.resp_valid, ifa.resp_err, a_we); end
    tick();
    checks++; if (a_inv_en !== 1'b0) begin errors++; $display("FAIL inv_pulse got %0h exp 0", a_inv_en); end
    req_a(TLB_OP_INV, 5'd0, 89'h0, 5'd7, 10'd3, 19'h12345);
    checks++; if (a_inv_en !== 1'b0 || ifa.resp_err !== 1'b1 || ifa.resp_valid !== 1'b1) begin
      errors++; $display("FAIL inv_bad got en=%0h err=%0h v=%0h exp 0 1 1", a_inv_en, ifa.resp_err, ifa.resp_valid); end
    tick();
    req_a(3'd6, 5'd3, 89'h1, 5'd0, 10'd0, 19'd0);
    checks++; if (ifa.resp_err !== 1'b1 || ifa.resp_valid !== 1'b1 || a_we !== 1'b0 || a_inv_en !== 1'b0) begin
      errors++; $display("FAIL bad_op got err=%0h v=%0h we=%0h inv=%0h exp 1 1 0 0", ifa.resp_err, ifa.resp_valid, a_we, a_inv_en); end
    tick();
    checks++; if (ifa.resp_err !== 1'b0) begin errors++; $display("FAIL err_clear got %0h exp 0", ifa.resp_err); end
  endtask

  task automatic test_back_to_back();
    ifa.req_valid = 1'b1; ifa.req_op = TLB_OP_SRCH; ifa.req_entry = 89'h48D140006;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (ifa.req_ready !== ((k % 4) == 0) || ifa.resp_valid !== ((k % 4) == 3)) begin
        errors++; $display("FAIL b2b_k%0d got r=%0h v=%0h exp %0h %0h", k, ifa.req_ready, ifa.resp_valid, (k % 4) == 0, (k % 4) == 3);
      end
    end
    ifa.req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    bit seen = 1'b0;
    req_a(TLB_OP_SRCH, 5'd0, 89'h48D140006, 5'd0, 10'd0, 19'd0);
    rst = 1'b0;
    #2;
    checks++; if (ifa.req_ready !== 1'b1 || a_srch_vppn !== 19'h0) begin
      errors++; $display("FAIL abort_async got r=%0h vppn=%0h exp 1 0", ifa.req_ready, a_srch_vppn); end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 1) rst = 1'b1;
      if (ifa.resp_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_resp got resp_valid 1 exp 0"); end
    req_a(TLB_OP_FILL, 5'd0, 89'h1, 5'd0, 10'd0, 19'd0);
    checks++; if (a_w_index !== 5'd0) begin errors++; $display("FAIL abort_fillctr got %0d exp 0", a_w_index); end
    tick();
  endtask

  initial begin
    ifa.req_valid = 1'b0; ifa.req_op = '0; ifa.req_index = '0; ifa.req_entry = '0;
    ifa.req_inv_op = '0; ifa.req_inv_asid = '0; ifa.req_inv_vpn = '0;
    ifb.req_valid = 1'b0; ifb.req_op = '0; ifb.req_index = '0; ifb.req_entry = '0;
    ifb.req_inv_op = '0; ifb.req_inv_asid = '0; ifb.req_inv_vpn = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    test_reset();
    test_write();
    test_fill();
    test_fill_wrap();
    test_search();
    test_read();
    test_inv();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
